// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential PC+4 or a word-aligned redirect target.
module pc_next #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_src,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  // Target low bits are dropped so a misaligned target can never reach memory.
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^pc_target[1:0];

  assign pc_plus4 = pc + ADDR_WIDTH'(4);
  assign next_pc  = pc_src ? {pc_target[ADDR_WIDTH-1:2], 2'b00} : pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch: REQ -> WAIT -> HOLD, then
// advance or redirect the PC when downstream consumes the held instruction.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    OP_WIDTH     = 7,
  parameter int                    FUNCT3_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data,
  input  logic                    Stall,
  input  logic                    PCSrc,
  input  logic [ADDR_WIDTH-1:0]   PCTarget,
  output logic [DATA_WIDTH-1:0]   Instr,
  output logic                    InstrValid,
  output logic [ADDR_WIDTH-1:0]   PC,
  output logic [ADDR_WIDTH-1:0]   PCPlus4,
  output logic [OP_WIDTH-1:0]     op,
  output logic [FUNCT3_WIDTH-1:0] funct3,
  output logic                    funct7_5
);

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_q, next_pc;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  instr_vld_q;
  logic                  load, consume;

  pc_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
    .pc       (pc_q),
    .pc_src   (PCSrc),
    .pc_target(PCTarget),
    .pc_plus4 (PCPlus4),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    load           = 1'b0;
    consume        = 1'b0;
    case (state)
      RESET: state_nxt = REQ;
      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = WAIT;
      end
      // Responses are only honoured here; anything arriving elsewhere is dropped.
      WAIT: begin
        if (imem_resp_valid) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!Stall) begin
          consume   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RESET;
      pc_q        <= RESET_PC;
      instr_q     <= DATA_WIDTH'(NOP_INSTR);
      instr_vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        instr_q     <= imem_resp_data;
        instr_vld_q <= 1'b1;
      end
      if (consume) begin
        pc_q        <= next_pc;
        instr_vld_q <= 1'b0;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_vld_q;
  assign op         = instr_q[OP_WIDTH-1:0];
  assign funct3     = instr_q[12 +: FUNCT3_WIDTH];
  assign funct7_5   = instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: address/instruction scoreboard queues fed at
// each consume and drained at each request/response.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        Stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;

  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_instr[$];
  logic [31:0] last_instr;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .Stall          (Stall),
    .PCSrc          (PCSrc),
    .PCTarget       (PCTarget),
    .Instr          (Instr),
    .InstrValid     (InstrValid),
    .PC             (PC),
    .PCPlus4        (PCPlus4),
    .op             (op),
    .funct3         (funct3),
    .funct7_5       (funct7_5)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1("req_timeout", imem_req_valid, 1'b1);
  endtask

  // One full fetch: optional ready back-pressure, response latency, stall in HOLD.
  task automatic do_fetch(input int ready_low, input int resp_dly, input int stall_cyc,
                          input logic src, input logic [31:0] tgt);
    logic [31:0] ea, ei, nxt;
    int t0;
    wait_req();
    t0 = cyc;
    ea = q_addr.pop_front();
    ei = q_instr.pop_front();
    chk("req_addr", imem_addr, ea);
    chk("pc_at_req", PC, ea);
    for (int i = 0; i < ready_low; i++) begin
      imem_resp_valid = (i == 1);
      imem_resp_data  = 32'hDEAD_BEEF;
      tick();
      chk1("req_hold_valid", imem_req_valid, 1'b1);
      chk("req_hold_addr", imem_addr, ea);
      chk("instr_spur_req", Instr, last_instr);
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk1("wait_no_req", imem_req_valid, 1'b0);
    for (int i = 1; i < resp_dly; i++) begin
      tick();
      chk1("wait_no_valid", InstrValid, 1'b0);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = ei;
    tick();
    imem_resp_valid = 1'b0;
    chk1("instr_valid", InstrValid, 1'b1);
    chk("instr", Instr, ei);
    chk("op", 32'(op), 32'(ei[6:0]));
    chk("funct3", 32'(funct3), 32'(ei[14:12]));
    chk1("funct7_5", funct7_5, ei[30]);
    chk("pc_hold", PC, ea);
    chk("pcplus4", PCPlus4, ea + 32'd4);
    for (int i = 0; i < stall_cyc; i++) begin
      Stall           = 1'b1;
      PCSrc           = (i == 2);
      PCTarget        = 32'h0000_0F00;
      imem_resp_valid = (i == 3);
      imem_resp_data  = 32'hDEAD_BEEF;
      tick();
      chk("stall_instr", Instr, ei);
      chk("stall_pc", PC, ea);
      chk1("stall_valid", InstrValid, 1'b1);
    end
    imem_resp_valid = 1'b0;
    Stall    = 1'b0;
    PCSrc    = src;
    PCTarget = tgt;
    nxt = src ? {tgt[31:2], 2'b00} : ea + 32'd4;
    q_addr.push_back(nxt);
    q_instr.push_back(mem_word(nxt));
    tick();
    PCSrc    = 1'b0;
    PCTarget = '0;
    chk1("consume_clr", InstrValid, 1'b0);
    chk1("next_req", imem_req_valid, 1'b1);
    chk("next_addr", imem_addr, nxt);
    if (ready_low == 0 && resp_dly == 1 && stall_cyc == 0)
      chk("period", 32'(cyc - t0), 32'd3);
    last_instr = ei;
  endtask

  initial begin
    logic [31:0] ea;
    last_instr = NOP_INSTR;
    rst_n = 1'b0;
    repeat (3) tick();
    chk1("rst_req", imem_req_valid, 1'b0);
    chk1("rst_valid", InstrValid, 1'b0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_pcplus4", PCPlus4, 32'h4);
    chk("rst_instr", Instr, NOP_INSTR);
    chk("rst_op", 32'(op), 32'h13);
    chk("rst_funct3", 32'(funct3), 32'h0);
    chk1("rst_funct7_5", funct7_5, 1'b0);

    rst_n = 1'b1;
    chk1("rel_no_req", imem_req_valid, 1'b0);
    tick();
    chk1("first_req", imem_req_valid, 1'b1);
    chk("first_addr", imem_addr, 32'h0);

    q_addr.push_back(32'h0);
    q_instr.push_back(mem_word(32'h0));
    repeat (4) do_fetch(0, 1, 0, 1'b0, 32'h0);
    do_fetch(4, 3, 5, 1'b1, 32'h0000_0103);
    do_fetch(1, 2, 0, 1'b1, 32'hFFFF_FFFF);
    do_fetch(0, 1, 2, 1'b0, 32'h0);
    do_fetch(0, 1, 0, 1'b0, 32'h0);

    // Reset while a response is outstanding.
    wait_req();
    ea = q_addr.pop_front();
    void'(q_instr.pop_front());
    chk("pre_rst_addr", imem_addr, ea);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk1("pre_rst_wait", imem_req_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_pc", PC, 32'h0);
    chk1("mid_rst_valid", InstrValid, 1'b0);
    chk1("mid_rst_req", imem_req_valid, 1'b0);
    chk("mid_rst_instr", Instr, NOP_INSTR);
    rst_n = 1'b1;
    tick();
    chk1("post_rst_req", imem_req_valid, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h0);
    q_addr.delete();
    q_instr.delete();
    q_addr.push_back(32'h0);
    q_instr.push_back(mem_word(32'h0));
    last_instr = NOP_INSTR;
    do_fetch(0, 1, 0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front-end that supplies the control unit and datapath with instructions. It holds the PC and issues one request at a time over a valid/ready instruction-memory interface. It registers the returned word and presents `Instr`, `PC`, `PCPlus4` and the decoded fields `op`, `funct3` and `funct7_5` until the downstream consumes them. It also consumes `PCSrc` and `PCTarget` to redirect the next fetch.

## Interface
- `ADDR_WIDTH`, 32, PC and memory address width.
- `DATA_WIDTH`, 32, instruction width (fixed at 32 for RV32I).
- `OP_WIDTH`, 7, opcode field width.
- `FUNCT3_WIDTH`, 3, funct3 field width.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  ADDR_WIDTH  fetch address, equal to `PC`.
- `imem_resp_valid`  in  1  response data valid.
- `imem_resp_data`  in  DATA_WIDTH  returned instruction.
- `Stall`  in  1  downstream not ready to consume the current instruction.
- `PCSrc`  in  1  take `PCTarget` as next PC.
- `PCTarget`  in  ADDR_WIDTH  branch/jump target.
- `Instr`  out  DATA_WIDTH  registered instruction.
- `InstrValid`  out  1  `Instr` is valid.
- `PC`  out  ADDR_WIDTH  address of `Instr` / current fetch.
- `PCPlus4`  out  ADDR_WIDTH  `PC + 4`.
- `op`  out  OP_WIDTH  `Instr[6:0]`.
- `funct3`  out  FUNCT3_WIDTH  `Instr[14:12]`.
- `funct7_5`  out  1  `Instr[30]`.

## Operation
- The unit uses a four-state FSM: RESET, REQ, WAIT, HOLD.
- **RESET:** entered while `rst_n`=0. Leaves to REQ on the first cycle with `rst_n`=1.
- **REQ:**
  - `imem_req_valid`=1 and `imem_addr`=`PC`.
  - Valid and address stay stable until `imem_req_ready`=1; that cycle counts as acceptance and the FSM goes to WAIT.
- **WAIT:** on `imem_resp_valid`=1, `Instr` is set to `imem_resp_data`, `InstrValid` is set to 1, and the FSM goes to HOLD.
- **HOLD:**
  - `Instr` and `PC` stay stable while `Stall`=1.
  - When `Stall`=0 the instruction is consumed:
    - `PC` is updated to `PCSrc ? {PCTarget[ADDR_WIDTH-1:2],2'b00} : PC+4`.
    - `InstrValid` is cleared to 0.
    - The FSM goes to REQ.
  - `PCSrc` is sampled only on a consume cycle; in all other states it is ignored.
- **Single outstanding request:** at most one request is in flight. `imem_resp_valid` is ignored outside WAIT.
- **Address arithmetic:** PC arithmetic is modulo 2^ADDR_WIDTH, so `PC`=FFFF_FFFC followed by +4 gives 0. `PCPlus4` wraps the same way.
- **Target alignment:** the low two bits of `PCTarget` are always discarded.
- **Field outputs:** `op`, `funct3` and `funct7_5` are combinational slices of the registered `Instr`.
- **Reset values:**
  - `PC`=`RESET_PC`, `PCPlus4`=`RESET_PC`+4.
  - `Instr`=32'h0000_0013 (NOP), so `op`=7'h13, `funct3`=0, `funct7_5`=0.
  - `InstrValid`=0, `imem_req_valid`=0.
- **Reset mid-operation:**
  - Reset aborts any state and returns to RESET.
  - Instruction memory shares `rst_n`, so no stale response is delivered after reset.

## Timing
- First request: `imem_req_valid` rises 1 cycle after `rst_n` deasserts.
- Acceptance to WAIT takes 1 cycle. The response may arrive 1 or more cycles after acceptance.
- `InstrValid` rises the cycle after `imem_resp_valid`.
- Consume to next `imem_req_valid`: 1 cycle, with the new `PC` already visible in that cycle.
- With zero-wait memory (ready=1, response 1 cycle after acceptance), peak throughput is one instruction every 3 cycles.
- `imem_req_valid` never drops without acceptance.
- `InstrValid` never drops without a consume or a reset.

## Structure
- **Package `fetch_pkg`:**
  - State enum `fetch_state_t` {RESET, REQ, WAIT, HOLD}.
  - Constant `NOP_INSTR` = 32'h0000_0013.
  - Default `RESET_PC`.
- **Sub-module `pc_next`:** combinational next-PC mux with `PCPlus4` adder and target alignment. It is instantiated once; the FSM and registers live in `fetch_unit`.

## Test plan
- Reset, then release with `RESET_PC`=0 and zero-wait memory returning 32'h00500093 → request at addr 0 one cycle after release. `InstrValid`=1 three cycles after release with `op`=7'h13, `funct3`=0.
- Sequential run with `Stall`=0 and `PCSrc`=0 → addresses 0, 4, 8, 12, with one instruction every 3 cycles.
- `imem_req_ready` low for 4 cycles → `imem_req_valid`=1 and `imem_addr` stable for all 4 cycles. One acceptance only.
- `Stall`=1 for 5 cycles in HOLD, with `PCSrc`=1 pulsed during the stall → `Instr`/`PC` stable and no redirect. On release with `PCSrc`=1 and `PCTarget`=32'h0000_0103 → next `imem_addr`=32'h0000_0100.
- Start at `PC`=32'hFFFF_FFFC and consume without branch → next `imem_addr`=0. Separately, a spurious `imem_resp_valid` in REQ/HOLD → `Instr` unchanged.
- `rst_n`=0 asserted during WAIT → next cycle `PC`=`RESET_PC`, `InstrValid`=0, `imem_req_valid`=0, `Instr`=NOP.
